// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor with a valid/ready handshake.
//
// Operands are split into S slices of W = N/S bits. Each pipeline stage
// ripples one slice using the carry registered by the previous stage, so a
// result takes S cycles and a new operand set can enter every cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   a, b                N-bit operands
//   cin                 carry-in (borrow-in when subtracting)
//   sub                 0 = a + b + cin, 1 = a - b - cin
//   in_valid/in_ready   input handshake (in_ready = pipeline may advance)
//   sum, cout, ovf      registered result, MSB carry-out, signed overflow
//   out_valid/out_ready output handshake

// One pipeline stage: ripples slice K and registers the partial result along
// with the operands still needed by later stages.
module pipelined_ripple_adder_stage #(
  parameter int N = 8,
  parameter int W = 4,
  parameter int K = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         vld_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  input  logic         cmsb_i,
  input  logic [N-1:0] sum_i,
  output logic         vld_q,
  output logic [N-1:0] a_q,
  output logic [N-1:0] b_q,
  output logic         c_q,
  output logic         cmsb_q,
  output logic [N-1:0] sum_q
);
  // The stage holding bit N-1 also captures the carry into that bit for ovf.
  localparam bit LAST = ((K + 1) * W == N);

  logic [W-1:0] as, bs, s;
  logic [W:0]   c;
  logic [N-1:0] sum_d;
  logic         cmsb_d;

  always_comb begin
    as = a_i[K*W +: W];
    bs = b_i[K*W +: W];
    s  = '0;
    c  = '0;
    c[0] = c_i;
    for (int j = 0; j < W; j++) begin
      s[j]   = as[j] ^ bs[j] ^ c[j];
      c[j+1] = (as[j] & bs[j]) | (c[j] & (as[j] ^ bs[j]));
    end
    sum_d = sum_i;
    sum_d[K*W +: W] = s;
    cmsb_d = LAST ? c[W-1] : cmsb_i;
  end

  // Data only loads with a valid entry, so a bubble reaching the output
  // leaves the last result bits in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      cmsb_q <= 1'b0;
      sum_q  <= '0;
    end else if (en_i) begin
      vld_q <= vld_i;
      if (vld_i) begin
        a_q    <= a_i;
        b_q    <= b_i;
        c_q    <= c[W];
        cmsb_q <= cmsb_d;
        sum_q  <= sum_d;
      end
    end
  end
endmodule

module pipelined_ripple_adder #(
  parameter int N = 8,
  parameter int S = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int W = N / S;

  // Index 0 is the combinational stage-0 input; index k+1 is stage k's register.
  logic         vld_p  [S+1];
  logic [N-1:0] a_p    [S+1];
  logic [N-1:0] b_p    [S+1];
  logic [N-1:0] sum_p  [S+1];
  logic         c_p    [S+1];
  logic         cm_p   [S+1];
  logic         advance;
  logic         unused_ops;

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign vld_p[0] = in_valid;
  assign a_p[0]   = a;
  assign b_p[0]   = b ^ {N{sub}};
  assign c_p[0]   = cin ^ sub;
  assign cm_p[0]  = 1'b0;
  assign sum_p[0] = '0;

  for (genvar k = 0; k < S; k++) begin : g_stage
    pipelined_ripple_adder_stage #(.N(N), .W(W), .K(k)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (advance),
      .vld_i  (vld_p[k]),
      .a_i    (a_p[k]),
      .b_i    (b_p[k]),
      .c_i    (c_p[k]),
      .cmsb_i (cm_p[k]),
      .sum_i  (sum_p[k]),
      .vld_q  (vld_p[k+1]),
      .a_q    (a_p[k+1]),
      .b_q    (b_p[k+1]),
      .c_q    (c_p[k+1]),
      .cmsb_q (cm_p[k+1]),
      .sum_q  (sum_p[k+1])
    );
  end

  // Operands are fully consumed by the last stage.
  assign unused_ops = ^{a_p[S], b_p[S]};

  assign out_valid = vld_p[S];
  assign sum       = sum_p[S];
  assign cout      = c_p[S];
  assign ovf       = cm_p[S] ^ c_p[S];
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
module tb_pipelined_ripple_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  a8, b8, sum8;
  logic        cin8, sub8, iv8, ir8, co8, ovf8, ovl8, or8;
  logic [0:0]  a1, b1, sum1;
  logic        cin1, sub1, iv1, ir1, co1, ovf1, ovl1, or1;
  logic [15:0] a16, b16, sum16;
  logic        cin16, sub16, iv16, ir16, co16, ovf16, ovl16, or16;

  pipelined_ripple_adder #(.N(8), .S(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .in_valid(iv8), .in_ready(ir8), .sum(sum8), .cout(co8), .ovf(ovf8),
    .out_valid(ovl8), .out_ready(or8));

  pipelined_ripple_adder #(.N(1), .S(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .in_valid(iv1), .in_ready(ir1), .sum(sum1), .cout(co1), .ovf(ovf1),
    .out_valid(ovl1), .out_ready(or1));

  pipelined_ripple_adder #(.N(16), .S(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .in_valid(iv16), .in_ready(ir16), .sum(sum16), .cout(co16), .ovf(ovf16),
    .out_valid(ovl16), .out_ready(or16));

  // Reference: {ovf, cout, sum} from plain integer arithmetic on n bits.
  function automatic logic [17:0] model(int n, logic [15:0] a, logic [15:0] b,
                                        logic cin, logic sub);
    longint mask, av, be, t, s;
    logic co, ov;
    mask = (longint'(1) << n) - 1;
    av = longint'(a) & mask;
    be = (longint'(b) ^ (sub ? mask : longint'(0))) & mask;
    t  = av + be + longint'(cin ^ sub);
    s  = t & mask;
    co = ((t >> n) & 1) != 0;
    ov = (av[n-1] == be[n-1]) && (s[n-1] != av[n-1]);
    return {ov, co, s[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {a8, b8, cin8, sub8, iv8} = '0;  or8 = 1'b1;
    {a1, b1, cin1, sub1, iv1} = '0;  or1 = 1'b1;
    {a16, b16, cin16, sub16, iv16} = '0; or16 = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #3;
    checks++;
    if ({ovl8, sum8, co8, ovf8} !== 11'd0) begin
      errors++; $display("FAIL reset_out8 got %b expected 0", {ovl8, sum8, co8, ovf8});
    end
    checks++;
    if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", ir8); end
    checks++;
    if ({ovl16, sum16, ovl1} !== 18'd0) begin
      errors++; $display("FAIL reset_out16 got %b expected 0", {ovl16, sum16, ovl1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic [7:0] va [8];
    logic [7:0] vb [8];
    logic       vc [8];
    logic       vs [8];
    logic [9:0] ex [8];
    va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0; vs[0] = 1'b0; ex[0] = {1'b0, 1'b1, 8'h00};
    va[1] = 8'h7F; vb[1] = 8'h01; vc[1] = 1'b0; vs[1] = 1'b0; ex[1] = {1'b1, 1'b0, 8'h80};
    va[2] = 8'h05; vb[2] = 8'h07; vc[2] = 1'b0; vs[2] = 1'b1; ex[2] = {1'b0, 1'b0, 8'hFE};
    va[3] = 8'h10; vb[3] = 8'h01; vc[3] = 1'b1; vs[3] = 1'b1; ex[3] = {1'b0, 1'b1, 8'h0E};
    for (int i = 4; i < 8; i++) begin
      logic [17:0] m;
      va[i] = 8'($urandom); vb[i] = 8'($urandom);
      vc[i] = 1'($urandom); vs[i] = 1'($urandom);
      m = model(8, {8'h00, va[i]}, {8'h00, vb[i]}, vc[i], vs[i]);
      ex[i] = {m[17], m[16], m[7:0]};
    end
    for (int i = 0; i < 8; i++) begin
      a8 = va[i]; b8 = vb[i]; cin8 = vc[i]; sub8 = vs[i]; iv8 = 1'b1; or8 = 1'b1;
      #1;
      checks++;
      if (ir8 !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got %b expected 1", i, ir8); end
      step();
      iv8 = 1'b0;
      sub8 = ~sub8; cin8 = ~cin8;
      checks++;
      if (ovl8 !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %b expected 0", i, ovl8); end
      step();
      checks++;
      if ({ovl8, ovf8, co8, sum8} !== {1'b1, ex[i]}) begin
        errors++;
        $display("FAIL dir%0d_result got v=%b ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                 i, ovl8, ovf8, co8, sum8, ex[i][9], ex[i][8], ex[i][7:0]);
      end
    end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    logic [17:0] q[$];
    logic [17:0] first, got;
    logic [7:0] la [3];
    logic [7:0] lb [3];
    int idx = 0, ndel = 0;
    int dcyc [3];
    la[0] = 8'h12; lb[0] = 8'h34;
    la[1] = 8'h80; lb[1] = 8'h80;
    la[2] = 8'h00; lb[2] = 8'h01;
    first = model(8, {8'h00, la[0]}, {8'h00, lb[0]}, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 12; cyc++) begin
      or8 = (cyc >= 6);
      iv8 = (idx < 3);
      if (idx < 3) begin a8 = la[idx]; b8 = lb[idx]; cin8 = 1'b0; sub8 = (idx == 2); end
      #1;
      if (cyc >= 2 && cyc < 6) begin
        checks++;
        if (ir8 !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready c%0d got %b expected 0", cyc, ir8); end
        checks++;
        if ({ovl8, ovf8, co8, sum8} !== {1'b1, first[17:16], first[7:0]}) begin
          errors++;
          $display("FAIL b2b_hold c%0d got v=%b %b%b %h expected 1 %b%b %h", cyc, ovl8, ovf8, co8,
                   sum8, first[17], first[16], first[7:0]);
        end
      end
      if (iv8 && ir8) begin
        q.push_back(model(8, {8'h00, a8}, {8'h00, b8}, cin8, sub8));
        idx++;
      end
      if (ovl8 && or8) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got sum=%h expected none", sum8);
        end else begin
          got = q.pop_front();
          if ({ovf8, co8, sum8} !== {got[17:16], got[7:0]}) begin
            errors++;
            $display("FAIL b2b_order%0d got %b%b %h expected %b%b %h", ndel, ovf8, co8, sum8,
                     got[17], got[16], got[7:0]);
          end
        end
        if (ndel < 3) dcyc[ndel] = cyc;
        ndel++;
      end
      step();
    end
    checks++;
    if (ndel !== 3) begin errors++; $display("FAIL b2b_count got %0d expected 3", ndel); end
    checks++;
    if (ndel >= 3 && (dcyc[0] != 6 || dcyc[1] != 7 || dcyc[2] != 8)) begin
      errors++;
      $display("FAIL b2b_rate got cycles %0d %0d %0d expected 6 7 8", dcyc[0], dcyc[1], dcyc[2]);
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    or8 = 1'b0; iv8 = 1'b1; cin8 = 1'b0; sub8 = 1'b0;
    a8 = 8'h33; b8 = 8'h44;
    step();
    a8 = 8'h11; b8 = 8'h22;
    step();
    iv8 = 1'b0;
    checks++;
    if ({ovl8, sum8} !== {1'b1, 8'h77}) begin
      errors++; $display("FAIL mid_pre_reset got v=%b sum=%h expected v=1 sum=77", ovl8, sum8);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ovl8, sum8, co8, ovf8} !== 11'd0) begin
      errors++; $display("FAIL mid_reset got v=%b sum=%h c=%b o=%b expected all 0", ovl8, sum8, co8, ovf8);
    end
    #2;
    rst_n = 1'b1;
    or8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({ovl8, sum8} !== 9'd0) begin
        errors++; $display("FAIL mid_stale c%0d got v=%b sum=%h expected v=0 sum=00", i, ovl8, sum8);
      end
    end
    idle();
  endtask

  task automatic test_full_adder();
    for (int i = 0; i < 8; i++) begin
      int tot;
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i); sub1 = 1'b0;
      iv1 = 1'b1; or1 = 1'b1;
      tot = int'(a1) + int'(b1) + int'(cin1);
      step();
      checks++;
      if ({ovl1, co1, sum1} !== {1'b1, 1'(tot / 2), 1'(tot % 2)}) begin
        errors++;
        $display("FAIL fa_%0d%0d%0d got v=%b cout=%b sum=%b expected v=1 cout=%0d sum=%0d",
                 a1, b1, cin1, ovl1, co1, sum1, tot / 2, tot % 2);
      end
    end
    idle();
    step();
  endtask

  task automatic test_random16();
    logic [17:0] q[$];
    logic [17:0] exp_v, prev;
    logic held = 1'b0;
    int nacc = 0, ndel = 0, nerr0 = errors;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      logic draining;
      draining = (cyc >= 1150);
      iv16 = draining ? 1'b0 : ($urandom_range(0, 9) < 7);
      or16 = draining ? 1'b1 : ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom);
      cin16 = 1'($urandom); sub16 = 1'($urandom);
      #1;
      checks++;
      if (ir16 !== (!ovl16 || or16)) begin
        errors++; $display("FAIL rnd_ready c%0d got %b expected %b", cyc, ir16, !ovl16 || or16);
      end
      if (held) begin
        checks++;
        if ({ovl16, ovf16, co16, sum16} !== {1'b1, prev}) begin
          errors++; $display("FAIL rnd_hold c%0d got %b %h expected held %h", cyc, ovl16, sum16, prev[15:0]);
        end
      end
      if (iv16 && ir16) begin
        q.push_back(model(16, a16, b16, cin16, sub16));
        nacc++;
      end
      if (ovl16 && or16) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra c%0d got sum=%h expected none", cyc, sum16);
        end else begin
          exp_v = q.pop_front();
          if ({ovf16, co16, sum16} !== exp_v) begin
            errors++;
            $display("FAIL rnd_result c%0d got %b%b %h expected %b%b %h", cyc, ovf16, co16, sum16,
                     exp_v[17], exp_v[16], exp_v[15:0]);
          end
        end
        ndel++;
      end
      held = ovl16 && !or16;
      prev = {ovf16, co16, sum16};
      step();
    end
    checks++;
    if (nacc !== ndel || q.size() != 0) begin
      errors++; $display("FAIL rnd_counts got accepted=%0d delivered=%0d expected equal", nacc, ndel);
    end
    checks++;
    if (errors != nerr0 || nacc < 100) begin
      errors++; $display("FAIL rnd_stream got mismatches=%0d accepted=%0d expected 0 and >=100",
                         errors - nerr0, nacc);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_full_adder();
    test_random16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_ripple_adder.md
PIPELINED_RIPPLE_ADDER -- requirements
Module: pipelined_ripple_adder

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand and sum width in bits (N >= 1).
REQ-002 The block SHALL have parameter S, default 2, giving the number of pipeline stages (1 <= S <= N, N divisible by S); each stage ripples W = N/S bits.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port a, input, N bits, operand A.
REQ-006 The block SHALL have port b, input, N bits, operand B.
REQ-007 The block SHALL have port cin, input, 1 bit, the carry-in (borrow-in when subtracting).
REQ-008 The block SHALL have port sub, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-009 The block SHALL have port in_valid, input, 1 bit, indicating that the operands are presented.
REQ-010 The block SHALL have port in_ready, output, 1 bit, indicating that the block accepts operands this cycle.
REQ-011 The block SHALL have port sum, output, N bits, the registered result.
REQ-012 The block SHALL have port cout, output, 1 bit, the registered carry-out of the MSB.
REQ-013 The block SHALL have port ovf, output, 1 bit, the registered two's-complement signed overflow.
REQ-014 The block SHALL have port out_valid, output, 1 bit, indicating that sum, cout and ovf hold a result.
REQ-015 The block SHALL have port out_ready, input, 1 bit, indicating that the consumer takes the result this cycle.

Function
REQ-016 The block SHALL form the effective operand as b ^ {N{sub}} and the effective carry-in as cin ^ sub, so that sub=1, cin=0 gives a-b and sub=1, cin=1 gives a-b-1.
REQ-017 The block SHALL compute the result as the N-bit sum of a, the effective operand and the effective carry-in, with cout equal to the raw carry out of bit N-1 (when subtracting, 1 = no borrow).
REQ-018 The block SHALL set ovf to the carry into bit N-1 XOR the carry out of bit N-1.
REQ-019 Stage k (0..S-1) SHALL ripple bits [k*W +: W] using the carry registered by stage k-1 (stage 0 uses the effective carry-in), and SHALL register its partial sum bits, its carry and the not-yet-summed operand bits together with a valid bit.
REQ-020 The block SHALL define advance = !out_valid || out_ready, and the whole pipeline SHALL shift one stage on every edge where advance=1 and SHALL hold all state where advance=0.
REQ-021 The block SHALL drive in_ready = advance combinationally; an input transfer occurs on an edge where in_valid && in_ready.
REQ-022 When stage 0 shifts with in_valid=0, the block SHALL insert a bubble (valid=0) and SHALL leave the output result bits unchanged when a bubble reaches the output.
REQ-023 Latency SHALL be S cycles: an operand set accepted at edge t SHALL appear with out_valid=1 after edge t+S-1 when there is no stall, and the block SHALL sustain a throughput of one result per cycle.
REQ-024 Results SHALL emerge in acceptance order with no loss or duplication under any out_ready pattern.
REQ-025 The block SHALL hold out_valid, sum, cout and ovf stable while out_valid=1 and out_ready=0.
REQ-026 When out_valid=1, out_ready=1 and in_valid=1 on the same edge, the block SHALL deliver the output and accept the input on that edge.
REQ-027 The sub and cin values SHALL be captured at acceptance and SHALL travel with their operands; later changes to these inputs SHALL not affect in-flight operations.
REQ-028 For S=1, the block SHALL behave as a registered N-bit adder with the same handshake.

Reset
REQ-029 While rst_n=0, the block SHALL immediately clear every stage valid bit, out_valid, sum, cout, ovf and all carries to 0, independent of clk.
REQ-030 After reset, in_ready SHALL be 1, and any operation in flight at reset assertion SHALL be discarded and never output.

Verification
REQ-031 With N=8, S=2, a=0xFF, b=0x01, cin=0, sub=0 accepted at edge t, the bench SHALL observe out_valid=1 after edge t+1 with sum=0x00, cout=1, ovf=0.
REQ-032 With N=8, S=2, a=0x7F+0x01 → sum=0x80, cout=0, ovf=1; sub=1 with 0x05-0x07 → sum=0xFE, cout=0, ovf=0; sub=1, cin=1 with 0x10-0x01 → sum=0x0E, cout=1.
REQ-033 The bench SHALL drive three back-to-back inputs with out_ready=0 for 4 cycles, then check that in_ready falls once the pipeline is full, that the outputs hold, and that the results drain in order at one per cycle once out_ready=1.
REQ-034 The bench SHALL assert rst_n low mid-stream with 2 operations in flight and check that out_valid=0 and sum=0 immediately, and that no stale result appears after release.
REQ-035 With N=1, S=1, sub=0, the bench SHALL apply all 8 {a,b,cin} combinations and match the full-adder truth table (e.g., 0,1,1 → sum=0, cout=1; 1,0,0 → sum=1, cout=0).
REQ-036 The bench SHALL run a random stream with N=16, S=4 and random in_valid/out_ready against a reference model (a + (b^{16{sub}}) + (cin^sub)) and check zero mismatches and equal transfer counts.
